uart_prog_loader: RTL and testbench
===================================

UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: byte address of first written word.
REQ-002 Parameter END_MARKER, default 32'hDEADBEEF: assembled word that terminates a load and is not written.
REQ-003 Parameter MAX_WORDS, default 4096: word limit per load; reaching it terminates the load.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 Rst  in  1  reset, synchronous, active-high.
REQ-006 prog  in  1  program-mode level; 1 = load requested.
REQ-007 rx_data  in  8  received UART byte.
REQ-008 rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
REQ-009 mem_ready  in  1  instruction memory accepts the pending write this cycle.
REQ-010 mem_addr  out  32  word-aligned write address.
REQ-011 mem_wdata  out  32  write data.
REQ-012 mem_wen  out  1  write request; held until accepted.
REQ-013 busy  out  1  load in progress; the core is held while 1.
REQ-014 done  out  1  last load completed via marker or MAX_WORDS.
REQ-015 word_count  out  16  words written in the current or last load.
REQ-016 err_overflow  out  1  sticky: a byte was dropped.

Function
REQ-017 States SHALL be IDLE, COLLECT, WRITE and DONE.
REQ-018 Bytes SHALL assemble little-endian: the 1st byte goes to [7:0] and the 4th byte to [31:24], so bytes ef,be,ad,de form 32'hDEADBEEF.
REQ-019 IDLE -> COLLECT SHALL occur on the first cycle with prog=1; that same edge sets mem_addr=BASE_ADDR, word_count=0, byte index=0, done=0 and err_overflow=0.
REQ-020 In COLLECT, each rx_valid SHALL store the byte and increment the byte index modulo 4.
REQ-021 On the 4th byte, if the word equals END_MARKER, the FSM SHALL go to DONE with no write; otherwise it SHALL go to WRITE with mem_wdata set to the word and mem_wen=1 on the next cycle.
REQ-022 In WRITE, mem_wen, mem_addr and mem_wdata SHALL stay stable until the cycle mem_ready=1 (zero-wait accept allowed).
REQ-023 The accept edge SHALL do all of: mem_wen=0, mem_addr+=4, word_count+=1, then go to DONE if the new count equals MAX_WORDS, else to COLLECT.
REQ-024 A byte arriving in WRITE SHALL be held in a 1-byte skid register; it is consumed as byte 0 on the first COLLECT cycle.
REQ-025 A byte arriving while the skid register is full SHALL be dropped and SHALL set err_overflow, which stays 1 until the next load start or Rst.
REQ-026 rx_valid on the same cycle as a WRITE accept SHALL be captured into the skid register, not lost.
REQ-027 If prog falls in COLLECT or WRITE, the FSM SHALL go to IDLE next edge: mem_wen=0, partial word discarded, done stays 0, word_count holds.
REQ-028 If prog falls in the same cycle as mem_ready, the abort SHALL take priority and the write is not counted.
REQ-029 DONE SHALL hold done=1 and busy=0 and ignore rx_valid; the FSM goes to IDLE when prog=0, and done stays 1 until the next load start.
REQ-030 busy SHALL be 1 exactly in COLLECT and WRITE.
REQ-031 mem_addr SHALL wrap modulo 2^32 and word_count SHALL saturate at 16'hFFFF.
REQ-032 rx_valid in IDLE SHALL be ignored.

Reset
REQ-033 Rst=1 SHALL, at the next edge, force IDLE with mem_addr=BASE_ADDR, mem_wdata=0, mem_wen=0, busy=0, done=0, word_count=0, err_overflow=0, skid empty and byte index 0.
REQ-034 Rst SHALL take priority over prog, rx_valid and mem_ready, including mid-write.

Verification
REQ-035 Basic load: prog=1; bytes 13,05,00,00, then ef,be,ad,de; mem_ready=1 -> one write addr 0x0 data 0x00000513; then done=1, word_count=1, busy=0.
REQ-036 Stalled memory: mem_ready held 0 for 5 cycles -> mem_wen, addr and data stable for all 5 cycles; accept on cycle 6; next address 0x4.
REQ-037 Skid buffer: one byte arrives during the stall -> it becomes byte 0 of the next word. A second byte during the same stall -> err_overflow=1 and that byte is absent from later data.
REQ-038 Abort: prog dropped after 2 bytes of word 3 -> IDLE, no write, done=0, word_count=2. A new prog=1 restarts at BASE_ADDR with count 0.
REQ-039 Limit: MAX_WORDS=2 with 3 words sent -> writes at 0x0 and 0x4 only; done=1; the 3rd word's bytes are ignored.
REQ-040 Reset mid-WRITE: Rst=1 while mem_wen=1 -> next cycle all outputs at reset values and no accept counted.

Source files
------------

// File: rtl/uart_prog_loader.sv
`default_nettype none
// ============================================================================
// uart_prog_loader: assembles UART bytes into little-endian words and writes
// them to instruction memory until an end marker or a word limit is reached.
// Revision: 1.0
// ============================================================================
module uart_prog_loader #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] END_MARKER = 32'hDEADBEEF,
    parameter int          MAX_WORDS  = 4096
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        prog,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wen,
    output logic        busy,
    output logic        done,
    output logic [15:0] word_count,
    output logic        err_overflow
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wen_q, wen_d;
    logic        done_q, done_d;
    logic [15:0] count_q, count_d;
    logic        ovf_q, ovf_d;
    logic [23:0] asm_q, asm_d;
    logic [1:0]  idx_q, idx_d;
    logic        skid_full_q, skid_full_d;
    logic [7:0]  skid_q, skid_d;

    logic        byte_vld;
    logic [7:0]  byte_val;
    logic [31:0] word_full;
    logic [15:0] count_inc;

    assign word_full = {byte_val, asm_q};
    assign count_inc = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wen_d       = wen_q;
        done_d      = done_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        asm_d       = asm_q;
        idx_d       = idx_q;
        skid_full_d = skid_full_q;
        skid_d      = skid_q;
        byte_vld    = 1'b0;
        byte_val    = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (prog) begin
                    state_d     = S_COLLECT;
                    addr_d      = BASE_ADDR;
                    count_d     = 16'd0;
                    idx_d       = 2'd0;
                    done_d      = 1'b0;
                    ovf_d       = 1'b0;
                    skid_full_d = 1'b0;
                end
            end

            S_COLLECT: begin
                if (!prog) begin
                    state_d     = S_IDLE;
                    idx_d       = 2'd0;
                    skid_full_d = 1'b0;
                end else begin
                    // A held skid byte is older than anything on rx, so it goes first
                    // and a simultaneous rx byte takes its place in the skid.
                    if (skid_full_q) begin
                        byte_vld    = 1'b1;
                        byte_val    = skid_q;
                        skid_full_d = rx_valid;
                        if (rx_valid) skid_d = rx_data;
                    end else if (rx_valid) begin
                        byte_vld = 1'b1;
                        byte_val = rx_data;
                    end

                    if (byte_vld) begin
                        idx_d = idx_q + 2'd1;
                        case (idx_q)
                            2'd0:    asm_d[7:0]   = byte_val;
                            2'd1:    asm_d[15:8]  = byte_val;
                            2'd2:    asm_d[23:16] = byte_val;
                            default: begin
                                if (word_full == END_MARKER) begin
                                    state_d = S_DONE;
                                    done_d  = 1'b1;
                                end else begin
                                    state_d = S_WRITE;
                                    wdata_d = word_full;
                                    wen_d   = 1'b1;
                                end
                            end
                        endcase
                    end
                end
            end

            S_WRITE: begin
                if (!prog) begin
                    state_d     = S_IDLE;
                    wen_d       = 1'b0;
                    idx_d       = 2'd0;
                    skid_full_d = 1'b0;
                end else begin
                    if (rx_valid) begin
                        if (skid_full_q) begin
                            ovf_d = 1'b1;
                        end else begin
                            skid_full_d = 1'b1;
                            skid_d      = rx_data;
                        end
                    end
                    if (mem_ready) begin
                        wen_d   = 1'b0;
                        addr_d  = addr_q + 32'd4;
                        count_d = count_inc;
                        if ({16'd0, count_inc} == 32'(MAX_WORDS)) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_COLLECT;
                        end
                    end
                end
            end

            default: begin
                if (!prog) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q     <= S_IDLE;
            addr_q      <= BASE_ADDR;
            wdata_q     <= 32'd0;
            wen_q       <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= 16'd0;
            ovf_q       <= 1'b0;
            asm_q       <= 24'd0;
            idx_q       <= 2'd0;
            skid_full_q <= 1'b0;
            skid_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wen_q       <= wen_d;
            done_q      <= done_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            asm_q       <= asm_d;
            idx_q       <= idx_d;
            skid_full_q <= skid_full_d;
            skid_q      <= skid_d;
        end
    end

    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign mem_wen      = wen_q;
    assign busy         = (state_q == S_COLLECT) || (state_q == S_WRITE);
    assign done         = done_q;
    assign word_count   = count_q;
    assign err_overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_prog_loader.sv
`default_nettype none
// ============================================================================
// tb_uart_prog_loader: directed and randomized checks of the UART program
// loader against expected word/address streams. Revision: 1.0
// ============================================================================
module tb_uart_prog_loader;

    localparam logic [31:0] MARKER = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        Rst, prog, prog2, rx_valid, mem_ready;
    logic [7:0]  rx_data;
    logic [31:0] mem_addr, mem_wdata, mem_addr2, mem_wdata2;
    logic        mem_wen, busy, done, err_overflow;
    logic        mem_wen2, busy2, done2, err_overflow2;
    logic [15:0] word_count, word_count2;

    int total = 0;
    int bad   = 0;
    logic [63:0] got_q[$];
    logic [63:0] got2_q[$];

    always #5 clk = ~clk;

    uart_prog_loader dut (
        .clk(clk), .Rst(Rst), .prog(prog), .rx_data(rx_data), .rx_valid(rx_valid),
        .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wen(mem_wen), .busy(busy), .done(done), .word_count(word_count),
        .err_overflow(err_overflow)
    );

    uart_prog_loader #(.MAX_WORDS(2)) dut2 (
        .clk(clk), .Rst(Rst), .prog(prog2), .rx_data(rx_data), .rx_valid(rx_valid),
        .mem_ready(mem_ready), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_wen(mem_wen2), .busy(busy2), .done(done2), .word_count(word_count2),
        .err_overflow(err_overflow2)
    );

    // Memory side: a write is taken when requested and ready, unless aborted or reset.
    always @(posedge clk) begin
        if (!Rst && prog && mem_wen && mem_ready) got_q.push_back({mem_addr, mem_wdata});
        if (!Rst && prog2 && mem_wen2 && mem_ready) got2_q.push_back({mem_addr2, mem_wdata2});
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic start_load();
        prog = 1'b0;
        @(negedge clk);
        prog = 1'b1;
        @(negedge clk);
        got_q.delete();
    endtask

    task automatic wait_done(input int budget, input string tag);
        for (int i = 0; i < budget && done !== 1'b1; i++) @(negedge clk);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL %s_done got=%b exp=1", tag, done); end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == MARKER) w = w ^ 32'h1;
        return w;
    endfunction

    task automatic test_reset();
        Rst = 1'b1; prog = 1'b0; prog2 = 1'b0; rx_valid = 1'b0; mem_ready = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        Rst = 1'b0;
        @(negedge clk);
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
        total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata); end
        total++; if ({mem_wen, busy, done, err_overflow} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got=%b exp=0000", {mem_wen, busy, done, err_overflow}); end
        total++; if (word_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", word_count); end
    endtask

    task automatic test_basic();
        start_load();
        mem_ready = 1'b1;
        send_word(32'h0000_0513);
        send_word(MARKER);
        wait_done(20, "basic");
        total++; if (got_q.size() != 1) begin bad++; $display("FAIL basic_nwrites got=%0d exp=1", got_q.size()); end
        total++; if (got_q[0] !== {32'h0, 32'h0000_0513}) begin bad++; $display("FAIL basic_write got=%h exp=%h", got_q[0], {32'h0, 32'h0000_0513}); end
        total++; if (word_count !== 16'd1) begin bad++; $display("FAIL basic_count got=%0d exp=1", word_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy got=%b exp=0", busy); end
        prog = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
    endtask

    logic [31:0] wa, wb;

    task automatic test_stall();
        start_load();
        mem_ready = 1'b0;
        wa = rand_word();
        send_word(wa);
        for (int i = 0; i < 5; i++) begin
            total++; if ({mem_wen, mem_addr, mem_wdata} !== {1'b1, 32'h0, wa}) begin
                bad++; $display("FAIL stall_hold%0d got=%b/%h/%h exp=1/0/%h", i, mem_wen, mem_addr, mem_wdata, wa); end
            @(negedge clk);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        total++; if ({mem_wen, mem_addr} !== {1'b0, 32'h4}) begin bad++; $display("FAIL stall_accept got=%b/%h exp=0/4", mem_wen, mem_addr); end
        total++; if (word_count !== 16'd1) begin bad++; $display("FAIL stall_count got=%0d exp=1", word_count); end
    endtask

    task automatic test_skid();
        logic [7:0]  s1, s2, b1, b2, b3;
        logic [31:0] wc;
        s1 = 8'($urandom); s2 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
        wc = {b3, b2, b1, s1};
        if (wc == MARKER) begin b1 = b1 ^ 8'h1; wc = {b3, b2, b1, s1}; end
        wb = rand_word();
        send_word(wb);
        send_byte(s1);
        send_byte(s2);
        total++; if (err_overflow !== 1'b1) begin bad++; $display("FAIL skid_ovf got=%b exp=1", err_overflow); end
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        send_byte(b1); send_byte(b2); send_byte(b3);
        @(negedge clk);
        mem_ready = 1'b1;
        @(negedge clk);
        send_word(MARKER);
        wait_done(20, "skid");
        total++; if (got_q.size() != 3) begin bad++; $display("FAIL skid_nwrites got=%0d exp=3", got_q.size()); end
        total++; if (got_q[0] !== {32'h0, wa}) begin bad++; $display("FAIL skid_w0 got=%h exp=%h", got_q[0], {32'h0, wa}); end
        total++; if (got_q[1] !== {32'h4, wb}) begin bad++; $display("FAIL skid_w1 got=%h exp=%h", got_q[1], {32'h4, wb}); end
        total++; if (got_q[2] !== {32'h8, wc}) begin bad++; $display("FAIL skid_w2 got=%h exp=%h", got_q[2], {32'h8, wc}); end
        total++; if ({err_overflow, word_count} !== {1'b1, 16'd3}) begin
            bad++; $display("FAIL skid_end got=%b/%0d exp=1/3", err_overflow, word_count); end
        prog = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_abort();
        logic [31:0] w4;
        start_load();
        total++; if ({busy, done, err_overflow, word_count, mem_addr} !== {3'b100, 16'd0, 32'h0}) begin
            bad++; $display("FAIL abort_start got=%b%b%b/%0d/%h exp=100/0/0", busy, done, err_overflow, word_count, mem_addr); end
        mem_ready = 1'b1;
        send_word(rand_word());
        send_word(rand_word());
        send_byte(8'h11);
        send_byte(8'h22);
        prog = 1'b0;
        @(negedge clk);
        total++; if ({busy, done, mem_wen} !== 3'b000) begin bad++; $display("FAIL abort_flags got=%b exp=000", {busy, done, mem_wen}); end
        total++; if (word_count !== 16'd2) begin bad++; $display("FAIL abort_count got=%0d exp=2", word_count); end
        total++; if (got_q.size() != 2) begin bad++; $display("FAIL abort_nwrites got=%0d exp=2", got_q.size()); end
        start_load();
        total++; if ({word_count, mem_addr} !== {16'd0, 32'h0}) begin
            bad++; $display("FAIL abort_restart got=%0d/%h exp=0/0", word_count, mem_addr); end
        w4 = rand_word();
        send_word(w4);
        send_word(MARKER);
        wait_done(20, "abort");
        total++; if (got_q.size() != 1 || got_q[0] !== {32'h0, w4}) begin
            bad++; $display("FAIL abort_rewrite got=%0d/%h exp=1/%h", got_q.size(), got_q[0], {32'h0, w4}); end
        prog = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_limit();
        logic [31:0] w[3];
        for (int i = 0; i < 3; i++) w[i] = rand_word();
        prog2 = 1'b1;
        @(negedge clk);
        got2_q.delete();
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_word(w[i]);
        repeat (3) @(negedge clk);
        total++; if (got2_q.size() != 2) begin bad++; $display("FAIL limit_nwrites got=%0d exp=2", got2_q.size()); end
        total++; if (got2_q[0] !== {32'h0, w[0]} || got2_q[1] !== {32'h4, w[1]}) begin
            bad++; $display("FAIL limit_writes got=%h,%h exp=%h,%h", got2_q[0], got2_q[1], {32'h0, w[0]}, {32'h4, w[1]}); end
        total++; if ({done2, busy2, mem_wen2, word_count2} !== {3'b100, 16'd2}) begin
            bad++; $display("FAIL limit_state got=%b%b%b/%0d exp=100/2", done2, busy2, mem_wen2, word_count2); end
        prog2 = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        start_load();
        mem_ready = 1'b0;
        send_word(rand_word());
        total++; if (mem_wen !== 1'b1) begin bad++; $display("FAIL rstw_pending got=%b exp=1", mem_wen); end
        Rst = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        total++; if ({mem_wen, busy, done, err_overflow} !== 4'b0000) begin
            bad++; $display("FAIL rstw_flags got=%b exp=0000", {mem_wen, busy, done, err_overflow}); end
        total++; if ({mem_addr, mem_wdata, word_count} !== 80'd0) begin
            bad++; $display("FAIL rstw_regs got=%h/%h/%0d exp=0/0/0", mem_addr, mem_wdata, word_count); end
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL rstw_accept got=%0d exp=0", got_q.size()); end
        Rst = 1'b0; mem_ready = 1'b0; prog = 1'b0;
        @(negedge clk);
    endtask

    // Bytes are paced so none lands while a write is pending; memory stalls randomly.
    task automatic test_random();
        logic [31:0] words[$];
        logic [7:0]  stream[$];
        int          n, guard;
        for (int it = 0; it < 3; it++) begin
            words.delete(); stream.delete();
            n = $urandom_range(3, 8);
            for (int i = 0; i < n; i++) words.push_back(rand_word());
            for (int i = 0; i < n; i++) for (int k = 0; k < 4; k++) stream.push_back(words[i][8*k +: 8]);
            for (int k = 0; k < 4; k++) stream.push_back(MARKER[8*k +: 8]);
            start_load();
            foreach (stream[j]) begin
                repeat ($urandom_range(0, 2)) begin mem_ready = 1'($urandom_range(0, 1)); @(negedge clk); end
                guard = 0;
                while (mem_wen === 1'b1 && guard < 100) begin
                    mem_ready = 1'($urandom_range(0, 1)); @(negedge clk); guard++;
                end
                if (guard >= 100) begin total++; bad++; $display("FAIL rand%0d_stuck got=wen1 exp=wen0", it); end
                send_byte(stream[j]);
            end
            mem_ready = 1'b1;
            wait_done(20, "rand");
            total++; if (got_q.size() != n) begin bad++; $display("FAIL rand%0d_nwrites got=%0d exp=%0d", it, got_q.size(), n); end
            for (int i = 0; i < n; i++) begin
                total++; if (got_q[i] !== {32'(4 * i), words[i]}) begin
                    bad++; $display("FAIL rand%0d_w%0d got=%h exp=%h", it, i, got_q[i], {32'(4 * i), words[i]}); end
            end
            total++; if ({busy, err_overflow, word_count} !== {2'b00, 16'(n)}) begin
                bad++; $display("FAIL rand%0d_end got=%b%b/%0d exp=00/%0d", it, busy, err_overflow, word_count, n); end
            prog = 1'b0; mem_ready = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_skid();
        test_abort();
        test_limit();
        test_reset_mid_write();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
